// File: rtl/panel_key_scanner_pkg.sv
// Shared front-panel definitions: scanner FSM encoding, keypad matrix geometry
// and small helpers for row decoding and column priority.
package panel_key_scanner_pkg;

   localparam int NUM_LINES  = 4;
   localparam int LINE_IDX_W = 2;
   localparam int KEY_CODE_W = 4;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_REPORT   = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_t;

   // Lowest-index active-low column wins when several are pressed together.
   function automatic logic [LINE_IDX_W-1:0] lowest_low_col(input logic [NUM_LINES-1:0] cols);
      logic [LINE_IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (!cols[i]) begin
            idx = LINE_IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [NUM_LINES-1:0] row_drive(input logic [LINE_IDX_W-1:0] row);
      return ~(NUM_LINES'(1) << row);
   endfunction

endpackage

// File: rtl/panel_key_scanner_if.sv
// Key handshake bundle between the keypad scanner (master) and its consumer.
interface panel_key_scanner_if;
   import panel_key_scanner_pkg::*;

   logic [KEY_CODE_W-1:0] key_code;
   logic                  key_valid;
   logic                  key_ready;
   logic                  key_down;

   modport master (output key_code, output key_valid, output key_down, input key_ready);
   modport slave  (input key_code, input key_valid, input key_down, output key_ready);

endinterface

// File: rtl/panel_key_scanner_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector;
// the pulse appears three clk cycles after the input edge.
module panel_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise_pulse
);

   logic [1:0] sync_reg;
   logic       prev_reg;
   logic       pulse_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg  <= 2'b00;
         prev_reg  <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], din};
         prev_reg  <= sync_reg[1];
         pulse_reg <= sync_reg[1] & ~prev_reg;
      end
   end

   assign rise_pulse = pulse_reg;

endmodule

// File: rtl/panel_key_scanner.sv
// 4x4 front-panel keypad scanner: walks the rows on each scan tick, debounces
// a press, hands the key code over a valid/ready handshake and waits for release.
module panel_key_scanner
   import panel_key_scanner_pkg::*;
#(
   parameter int DEBOUNCE_N = 4,
   parameter int CNT_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scan_clk,
   input  logic [NUM_LINES-1:0] col_in,
   output logic [NUM_LINES-1:0] row_out,
   panel_key_scanner_if.master  key_if
);

   localparam logic [CNT_W-1:0] DBN_CNT = CNT_W'(DEBOUNCE_N);

   logic                  scan_tick;
   logic [NUM_LINES-1:0]  col_meta_reg;
   logic [NUM_LINES-1:0]  col_sync_reg;

   scan_state_t           state_reg;
   logic [LINE_IDX_W-1:0] row_reg;
   logic [NUM_LINES-1:0]  row_out_reg;
   logic [KEY_CODE_W-1:0] code_reg;
   logic [CNT_W-1:0]      count_reg;
   logic                  valid_reg;
   logic                  down_reg;

   logic [CNT_W-1:0]      count_inc;
   logic [LINE_IDX_W-1:0] row_inc;
   logic                  captured_low;

   panel_sync_edge u_scan_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (scan_clk),
      .rise_pulse (scan_tick)
   );

   // Idle keypad columns read high, so the synchronizer resets to all ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_meta_reg <= '1;
         col_sync_reg <= '1;
      end else begin
         col_meta_reg <= col_in;
         col_sync_reg <= col_meta_reg;
      end
   end

   assign count_inc    = count_reg + CNT_W'(1);
   assign row_inc      = row_reg + LINE_IDX_W'(1);
   assign captured_low = ~col_sync_reg[code_reg[LINE_IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_SCAN;
         row_reg     <= '0;
         row_out_reg <= row_drive('0);
         code_reg    <= '0;
         count_reg   <= '0;
         valid_reg   <= 1'b0;
         down_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_SCAN: begin
               if (scan_tick) begin
                  if (&col_sync_reg) begin
                     row_reg     <= row_inc;
                     row_out_reg <= row_drive(row_inc);
                  end else begin
                     code_reg  <= {row_reg, lowest_low_col(col_sync_reg)};
                     count_reg <= CNT_W'(1);
                     // A single-tick debounce qualifies on the capture tick itself.
                     if (DBN_CNT == CNT_W'(1)) begin
                        state_reg <= ST_REPORT;
                        valid_reg <= 1'b1;
                        down_reg  <= 1'b1;
                     end else begin
                        state_reg <= ST_DEBOUNCE;
                     end
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (scan_tick) begin
                  if (captured_low) begin
                     count_reg <= count_inc;
                     if (count_inc == DBN_CNT) begin
                        state_reg <= ST_REPORT;
                        valid_reg <= 1'b1;
                        down_reg  <= 1'b1;
                     end
                  end else begin
                     state_reg   <= ST_SCAN;
                     count_reg   <= '0;
                     row_reg     <= row_inc;
                     row_out_reg <= row_drive(row_inc);
                  end
               end
            end
            ST_REPORT: begin
               // The handshake runs at clk rate, not at scan-tick rate.
               if (valid_reg && key_if.key_ready) begin
                  valid_reg <= 1'b0;
                  state_reg <= ST_RELEASE;
                  count_reg <= '0;
               end
            end
            ST_RELEASE: begin
               if (scan_tick) begin
                  if (!captured_low) begin
                     count_reg <= count_inc;
                     if (count_inc == DBN_CNT) begin
                        down_reg    <= 1'b0;
                        state_reg   <= ST_SCAN;
                        count_reg   <= '0;
                        row_reg     <= row_inc;
                        row_out_reg <= row_drive(row_inc);
                     end
                  end else begin
                     count_reg <= '0;
                  end
               end
            end
            default: begin
               state_reg <= ST_SCAN;
            end
         endcase
      end
   end

   assign row_out          = row_out_reg;
   assign key_if.key_code  = code_reg;
   assign key_if.key_valid = valid_reg;
   assign key_if.key_down  = down_reg;

endmodule

// File: tb/tb_panel_key_scanner.sv
// Self-checking bench for panel_key_scanner: keypad matrix model, vector table,
// hand-written corner sequences and a randomized run against a tick-level model.
module tb_panel_key_scanner;

   localparam int DBN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_clk = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] key_mask = '0;
   logic        use_direct = 1'b0;
   logic [3:0]  col_direct = 4'hF;
   logic [3:0]  kp_cols;

   panel_key_scanner_if kif ();

   panel_key_scanner #(.DEBOUNCE_N(DBN), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scan_clk (scan_clk),
      .col_in   (col_in),
      .row_out  (row_out),
      .key_if   (kif)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its column low while its row is driven.
   always_comb begin
      kp_cols = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row_out[r]) kp_cols = kp_cols & ~key_mask[r*4 +: 4];
      end
   end
   assign col_in = use_direct ? col_direct : kp_cols;

   int         checks = 0;
   int         errors = 0;
   int         xfer_cnt = 0;
   logic [3:0] last_code = '0;
   int         valid_cycles = 0;
   int         cur_run = 0;
   int         max_run = 0;
   int         bad_hold = 0;
   logic       watch_hold = 1'b0;
   logic [3:0] hold_code = '0;

   always @(negedge clk) begin
      if (kif.key_valid) begin
         valid_cycles++;
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else begin
         cur_run = 0;
      end
      if (rst_n && kif.key_valid && kif.key_ready) begin
         xfer_cnt++;
         last_code = kif.key_code;
      end
      if (watch_hold && (!kif.key_valid || kif.key_code != hold_code)) bad_hold++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   function automatic logic [3:0] exp_row(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << (r % 4));
   endfunction

   function automatic int lowest_zero(input logic [3:0] c);
      for (int i = 0; i < 4; i++) if (!c[i]) return i;
      return 0;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full scan_clk period; the tick acts four clk edges after the rise.
   task automatic do_tick();
      scan_clk = 1'b1;
      wait_clk(4);
      scan_clk = 1'b0;
      wait_clk(4);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(3);
   endtask

   typedef struct {
      logic [15:0] mask;
      int          exp_code;
      int          exp_tick;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int x0, v0, got_tick;
      int m_row, m_phase, m_run, m_code;
      logic [3:0] mc;
      logic [15:0] one16;
      bit rep;

      vecs[0] = '{16'h0200, 9, 6};
      vecs[1] = '{16'h000A, 1, 4};
      vecs[2] = '{16'h0001, 0, 4};
      vecs[3] = '{16'h8000, 15, 7};
      vecs[4] = '{16'h0050, 4, 5};
      vecs[5] = '{16'h4004, 2, 4};
      vecs[6] = '{16'h2080, 7, 5};
      vecs[7] = '{16'h0C00, 10, 6};

      kif.key_ready = 1'b1;
      one16 = 16'h0001;

      // Reset state and idle row walk
      key_mask = '0;
      apply_reset();
      check("reset_row_out", row_out, 4'hE);
      check("reset_valid", kif.key_valid, 0);
      check("reset_down", kif.key_down, 0);
      check("reset_code", kif.key_code, 0);
      v0 = valid_cycles;
      for (int k = 1; k <= 8; k++) begin
         do_tick();
         check($sformatf("idle_row_t%0d", k), row_out, exp_row(k));
      end
      check("idle_no_valid", valid_cycles - v0, 0);

      // Vector table: press from reset, expect code at tick row+DBN, then release
      max_run = 0;
      foreach (vecs[i]) begin
         key_mask = vecs[i].mask;
         apply_reset();
         x0 = xfer_cnt;
         got_tick = 0;
         for (int t = 1; t <= 10 && got_tick == 0; t++) begin
            do_tick();
            if (xfer_cnt != x0) got_tick = t;
         end
         check($sformatf("vec%0d_tick", i), got_tick, vecs[i].exp_tick);
         check($sformatf("vec%0d_code", i), last_code, vecs[i].exp_code);
         check($sformatf("vec%0d_xfers", i), xfer_cnt - x0, 1);
         check($sformatf("vec%0d_down", i), kif.key_down, 1);
         key_mask = '0;
         for (int k = 1; k <= DBN; k++) begin
            do_tick();
            check($sformatf("vec%0d_rel_down_t%0d", i, k), kif.key_down, (k < DBN) ? 1 : 0);
         end
         check($sformatf("vec%0d_rel_row", i), row_out, exp_row(vecs[i].exp_code / 4 + 1));
      end
      check("valid_width_ready_early", max_run, 1);

      // Bounce: column 0 low 2 ticks, high 1, low 4
      use_direct = 1'b1;
      col_direct = 4'hF;
      apply_reset();
      x0 = xfer_cnt;
      col_direct = 4'hE;
      do_ticks(2);
      col_direct = 4'hF;
      do_tick();
      check("bounce_no_report", xfer_cnt - x0, 0);
      col_direct = 4'hE;
      do_ticks(3);
      check("bounce_not_yet", xfer_cnt - x0, 0);
      do_tick();
      check("bounce_one_report", xfer_cnt - x0, 1);
      check("bounce_code", last_code, 4);
      col_direct = 4'hF;
      do_ticks(DBN);
      check("bounce_released", kif.key_down, 0);
      use_direct = 1'b0;

      // Stalled consumer with a second key pressed during REPORT
      kif.key_ready = 1'b0;
      key_mask = 16'h0200;
      apply_reset();
      do_ticks(6);
      check("stall_valid", kif.key_valid, 1);
      check("stall_code", kif.key_code, 9);
      x0 = xfer_cnt;
      key_mask = 16'h0300;
      hold_code = 4'd9;
      bad_hold = 0;
      watch_hold = 1'b1;
      do_ticks(3);
      watch_hold = 1'b0;
      check("stall_hold_stable", bad_hold, 0);
      check("stall_no_xfer", xfer_cnt - x0, 0);
      kif.key_ready = 1'b1;
      wait_clk(2);
      check("stall_xfer", xfer_cnt - x0, 1);
      check("stall_xfer_code", last_code, 9);
      check("stall_valid_drop", kif.key_valid, 0);
      key_mask = 16'h0100;
      do_ticks(DBN);
      check("stall_rel_down", kif.key_down, 0);
      check("stall_rel_row", row_out, exp_row(3));
      check("stall_second_ignored", xfer_cnt - x0, 1);
      got_tick = 0;
      x0 = xfer_cnt;
      for (int t = 1; t <= 10 && got_tick == 0; t++) begin
         do_tick();
         if (xfer_cnt != x0) got_tick = t;
      end
      check("second_key_tick", got_tick, 7);
      check("second_key_code", last_code, 8);
      key_mask = '0;
      do_ticks(DBN);

      // Reset while a key is pending
      kif.key_ready = 1'b0;
      key_mask = 16'h0200;
      apply_reset();
      do_ticks(6);
      check("rstmid_pre_valid", kif.key_valid, 1);
      x0 = xfer_cnt;
      rst_n = 1'b0;
      wait_clk(1);
      rst_n = 1'b1;
      check("rstmid_valid", kif.key_valid, 0);
      check("rstmid_row_out", row_out, 4'hE);
      check("rstmid_down", kif.key_down, 0);
      check("rstmid_code", kif.key_code, 0);
      key_mask = '0;
      kif.key_ready = 1'b1;
      wait_clk(3);
      do_tick();
      check("rstmid_first_tick_row", row_out, exp_row(1));
      check("rstmid_no_xfer", xfer_cnt - x0, 0);

      // Randomized key activity against a tick-level reference model
      key_mask = '0;
      apply_reset();
      m_row = 0;
      m_phase = 0;
      m_run = 0;
      m_code = 0;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0: key_mask = '0;
               1, 2: key_mask = one16 << $urandom_range(0, 15);
               default: key_mask = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
            endcase
         end
         x0 = xfer_cnt;
         do_tick();
         mc = ~key_mask[m_row*4 +: 4];
         rep = 1'b0;
         if (m_phase == 0) begin
            if (mc == 4'hF) begin
               m_row = (m_row + 1) % 4;
            end else begin
               m_code = m_row * 4 + lowest_zero(mc);
               m_run = 1;
               if (m_run >= DBN) begin
                  rep = 1'b1;
                  m_phase = 2;
                  m_run = 0;
               end else begin
                  m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (!mc[m_code % 4]) begin
               m_run++;
               if (m_run == DBN) begin
                  rep = 1'b1;
                  m_phase = 2;
                  m_run = 0;
               end
            end else begin
               m_phase = 0;
               m_run = 0;
               m_row = (m_row + 1) % 4;
            end
         end else begin
            if (mc[m_code % 4]) begin
               m_run++;
               if (m_run == DBN) begin
                  m_phase = 0;
                  m_run = 0;
                  m_row = (m_row + 1) % 4;
               end
            end else begin
               m_run = 0;
            end
         end
         check($sformatf("rnd%0d_row", n), row_out, exp_row(m_row));
         check($sformatf("rnd%0d_down", n), kif.key_down, (m_phase == 2) ? 1 : 0);
         check($sformatf("rnd%0d_xfers", n), xfer_cnt - x0, rep ? 1 : 0);
         if (rep) check($sformatf("rnd%0d_code", n), last_code, m_code);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/panel_key_scanner.md
PANEL_KEY_SCANNER -- requirements
Module: panel_key_scanner

Interface
REQ-001 Parameter DEBOUNCE_N, default 4: consecutive stable scan ticks required for key press and release qualification; legal range 1..15.
REQ-002 Parameter CNT_W, default 4: width of the debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_N.
REQ-003 Port clk  input  1: single system clock, all logic on posedge.
REQ-004 Port rst_n  input  1: synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port scan_clk  input  1: divided scan clock from the front-panel clock divider; treated as data, never as a clock.
REQ-006 Port col_in  input  4: keypad column lines, active-low, asynchronous to clk.
REQ-007 Port row_out  output  4: keypad row drives, active-low, exactly one bit low at any time after reset.
REQ-008 Port key_code  output  4: qualified key index, row*4+col.
REQ-009 Port key_valid  output  1: key_code holds a qualified press.
REQ-010 Port key_ready  input  1: consumer accepts key_code.
REQ-011 Port key_down  output  1: high from press qualification until release qualification.

Function
REQ-012 scan_clk and col_in SHALL each pass through a 2-flop synchronizer; scan tick = one-clk pulse on the synchronized scan_clk rising edge (latency 3 clk from the input edge).
REQ-013 Other than state entry on reset, all state changes, counter updates and row changes SHALL occur only on tick cycles; between ticks all registers hold.
REQ-014 FSM states: SCAN, DEBOUNCE, REPORT, RELEASE.
REQ-015 SCAN, tick, all synced columns high: row index increments mod 4, row_out = ~(1<<row).
REQ-016 SCAN, tick, any column low: capture code = row*4 + lowest-index low column, count=1, go to DEBOUNCE, row held.
REQ-017 DEBOUNCE, tick, same column low: count+1; when count reaches DEBOUNCE_N, go to REPORT.
REQ-018 DEBOUNCE, tick, captured column high: go to SCAN and advance row; a different column also low is ignored.
REQ-019 DEBOUNCE_N=1: REPORT entered on the same tick as capture.
REQ-020 REPORT: key_valid=1, key_down=1, key_code stable; transfer on a clk cycle with key_valid & key_ready, independent of tick.
REQ-021 On transfer, key_valid=0 next cycle and the FSM goes to RELEASE with count=0.
REQ-022 key_ready high before key_valid rises: transfer SHALL occur on the first valid cycle (valid high exactly 1 clk).
REQ-023 RELEASE, tick: captured column high -> count+1, else count=0; at DEBOUNCE_N, key_down=0, go to SCAN, advance row.
REQ-024 Presses of other keys during REPORT/RELEASE SHALL be ignored; no queueing, at most one code outstanding.
REQ-025 key_code SHALL hold its last value when key_valid=0.

Reset
REQ-026 While rst_n=0 at posedge: state=SCAN, row=0, row_out=4'b1110, key_valid=0, key_down=0, key_code=0, count=0, synchronizers=all ones for col, zero for scan_clk.
REQ-027 Reset mid-operation (any state, including valid pending) SHALL discard the key without transfer; first tick after reset is evaluated from SCAN row 0.

Structure
REQ-028 Shared front-panel package SHALL hold the FSM state encoding, row/column count constant (4) and key_code width.
REQ-029 One sub-module, panel_sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated for scan_clk; col_in uses a vectorised 2-flop synchronizer.
REQ-030 No derived clocks, no latches; target 150-300 RTL lines.

Verification
REQ-031 Reset, col_in=4'hF, 8 ticks -> row_out cycles 1110,1101,1011,0111,1110...; key_valid never high.
REQ-032 Row 2 driven, col 1 held low 4 ticks, key_ready=1 -> key_code=4'd9, key_valid high 1 clk, key_down=1 until 4 release ticks.
REQ-033 Bounce: col 0 low 2 ticks, high 1, low 4 -> no report after the first burst; one report, code=row*4+0, after the second.
REQ-034 key_ready=0 for 20 clk in REPORT, second key pressed meanwhile -> key_valid and key_code stable throughout; only first key reported; second key ignored until release qualifies.
REQ-035 Columns 1 and 3 low simultaneously on row 0 -> key_code=4'd1.
REQ-036 rst_n low 1 cycle while key_valid=1 -> key_valid=0 next cycle, row_out=4'b1110, no transfer observed.
